ravenoc_rx_depacketizer: RTL and testbench

Drains flits from the RaveNoC ejection FIFO read port and turns them back into packets. Each packet is one head flit followed by body/tail flits; the block emits the payload as a valid/ready word stream with source ID and last marker. It checks flit-type sequencing and length, reporting violations as error pulses. It sits between the FIFO (`read_i`/`data_o`/`empty_o` side) and the local consumer.

---
 rtl/ravenoc_pkg.sv | 21 ++
 rtl/ravenoc_rx_depacketizer.sv | 188 ++++++++++++++++++
 tb/tb_ravenoc_rx_depacketizer.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ravenoc_pkg.sv
// Shared RaveNoC definitions: flit types, head field positions and error codes.
package ravenoc_pkg;

    typedef enum logic [1:0] {
        HEAD = 2'b00,
        BODY = 2'b01,
        TAIL = 2'b10,
        RSVD = 2'b11
    } flit_type_t;

    localparam int HEAD_SRC_LSB = 24;
    localparam int HEAD_LEN_LSB = 16;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_TYPE  = 2'b01,
        ERR_LEN   = 2'b10,
        ERR_ABORT = 2'b11
    } err_code_t;

endpackage

// File: rtl/ravenoc_rx_depacketizer.sv
// Ejection-FIFO depacketizer: turns head/body/tail flits back into a valid/ready
// payload stream with source ID and last marker, flagging sequencing/length errors.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a head flit; anything else is popped and flagged
// PAYLOAD | delivering body/tail payload of the current packet
// DRAIN   | packet overran its length; discard flits until tail or head
module ravenoc_rx_depacketizer
    import ravenoc_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int LEN_W = 8,
    parameter int SRC_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [WIDTH-1:0] fifo_data_i,
    input  logic             fifo_empty_i,
    output logic             fifo_read_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [31:0]      m_data_o,
    output logic             m_last_o,
    output logic [SRC_W-1:0] m_src_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [CNT_W-1:0] pkt_count_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_PAYLOAD = 2'b01,
        S_DRAIN   = 2'b10
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = 1;
    localparam logic [CNT_W-1:0] PKT_ONE = 1;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    logic               valid_q;
    logic [31:0]        data_q;
    logic               last_q;
    logic [SRC_W-1:0]   osrc_q;
    logic               err_q;
    logic [1:0]         code_q;
    logic [CNT_W-1:0]   pkt_cnt_q;

    flit_type_t         ftype;
    logic [SRC_W-1:0]   head_src;
    logic [LEN_W-1:0]   head_len;
    logic               at_end;
    logic               slot_free;
    logic               rd;
    logic               load;
    logic               last_d;
    logic               err_d;
    err_code_t          code_d;

    assign ftype     = flit_type_t'(fifo_data_i[WIDTH-1:WIDTH-2]);
    assign head_src  = fifo_data_i[HEAD_SRC_LSB +: SRC_W];
    assign head_len  = fifo_data_i[HEAD_LEN_LSB +: LEN_W];
    assign at_end    = (cnt_q == len_q - LEN_ONE);
    assign slot_free = !valid_q || m_ready_i;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        rd      = 1'b0;
        load    = 1'b0;
        last_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_i) begin
                    rd = 1'b1;
                    if (ftype == HEAD) begin
                        if (head_len != '0) begin
                            src_d   = head_src;
                            len_d   = head_len;
                            cnt_d   = '0;
                            state_d = S_PAYLOAD;
                        end else begin
                            err_d  = 1'b1;
                            code_d = ERR_LEN;
                        end
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_TYPE;
                    end
                end
            end
            S_PAYLOAD: begin
                if (!fifo_empty_i) begin
                    // A head is left in the FIFO so IDLE can start the new packet from it.
                    if (ftype == HEAD) begin
                        err_d   = 1'b1;
                        code_d  = ERR_ABORT;
                        state_d = S_IDLE;
                    end else if (slot_free) begin
                        rd = 1'b1;
                        if (ftype == RSVD) begin
                            err_d  = 1'b1;
                            code_d = ERR_TYPE;
                        end else begin
                            load   = 1'b1;
                            last_d = (ftype == TAIL) || at_end;
                            cnt_d  = cnt_q + LEN_ONE;
                            if (ftype == TAIL) begin
                                state_d = S_IDLE;
                                if (!at_end) begin
                                    err_d  = 1'b1;
                                    code_d = ERR_LEN;
                                end
                            end else if (at_end) begin
                                err_d   = 1'b1;
                                code_d  = ERR_LEN;
                                state_d = S_DRAIN;
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!fifo_empty_i) begin
                    if (ftype == HEAD) begin
                        state_d = S_IDLE;
                    end else begin
                        rd = 1'b1;
                        if (ftype == TAIL) state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            osrc_q    <= '0;
            err_q     <= 1'b0;
            code_q    <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            if (load) begin
                valid_q <= 1'b1;
                data_q  <= fifo_data_i[31:0];
                last_q  <= last_d;
                osrc_q  <= src_q;
            end else if (m_ready_i) begin
                valid_q <= 1'b0;
            end
            err_q  <= err_d;
            code_q <= code_d;
            if (valid_q && m_ready_i && last_q) pkt_cnt_q <= pkt_cnt_q + PKT_ONE;
        end
    end

    // The pop strobe is combinational, so it must be gated to stay quiet in reset.
    assign fifo_read_o = rd & arst;
    assign m_valid_o   = valid_q;
    assign m_data_o    = data_q;
    assign m_last_o    = last_q;
    assign m_src_o     = osrc_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;
    assign pkt_count_o = pkt_cnt_q;

endmodule

// File: tb/tb_ravenoc_rx_depacketizer.sv
// Randomized bench for ravenoc_rx_depacketizer against a flit-stream parsing model.
module tb_ravenoc_rx_depacketizer;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic [7:0]  s;
    } word_t;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic [33:0] fifo_data_i = '0;
    logic        fifo_empty_i = 1'b1;
    logic        m_ready_i = 1'b0;
    logic        fifo_read_o, m_valid_o, m_last_o, err_o;
    logic [31:0] m_data_o;
    logic [7:0]  m_src_o;
    logic [1:0]  err_code_o;
    logic [15:0] pkt_count_o;

    logic        w_fifo_read_o, w_m_valid_o, w_m_last_o, w_err_o;
    logic [31:0] w_m_data_o;
    logic [7:0]  w_m_src_o;
    logic [1:0]  w_err_code_o;
    logic [1:0]  w_pkt_count_o;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [33:0] fq[$];
    logic [33:0] batch[$];
    word_t       exp_w[$];
    logic [1:0]  exp_e[$];
    int          acc_cyc[$];
    int          cyc = 0;
    int          model_cnt = 0;
    int          ready_mode = 0;
    logic        rd_seen = 1'b0;
    logic        hold_pending = 1'b0;
    word_t       hold_w;

    ravenoc_rx_depacketizer dut (
        .clk(clk), .arst(arst), .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i),
        .fifo_read_o(fifo_read_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_data_o(m_data_o), .m_last_o(m_last_o), .m_src_o(m_src_o), .err_o(err_o),
        .err_code_o(err_code_o), .pkt_count_o(pkt_count_o)
    );

    // Narrow-counter copy on the same stream, so wrap-around is reached quickly.
    ravenoc_rx_depacketizer #(.CNT_W(2)) dut_w (
        .clk(clk), .arst(arst), .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i),
        .fifo_read_o(w_fifo_read_o), .m_valid_o(w_m_valid_o), .m_ready_i(m_ready_i),
        .m_data_o(w_m_data_o), .m_last_o(w_m_last_o), .m_src_o(w_m_src_o), .err_o(w_err_o),
        .err_code_o(w_err_code_o), .pkt_count_o(w_pkt_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] head(input logic [7:0] src, input logic [7:0] len);
        return {2'b00, src, len, 16'h0000};
    endfunction

    function automatic logic [33:0] fl(input logic [1:0] t, input logic [31:0] d);
        return {t, d};
    endfunction

    // FIFO and ready driver: pops what the DUT strobed, then presents the next head entry.
    initial begin
        forever begin
            @(posedge clk);
            if (rd_seen && fq.size() > 0) void'(fq.pop_front());
            #1;
            fifo_empty_i = (fq.size() == 0);
            fifo_data_i  = fifo_empty_i ? {$urandom, $urandom} : fq[0];
            m_ready_i    = (ready_mode == 0) ? 1'b1 :
                           (ready_mode == 1) ? ($urandom_range(0, 9) < 7) : 1'b0;
        end
    end

    // Monitor/scoreboard, sampled on the falling edge.
    initial begin
        word_t e;
        forever begin
            @(negedge clk);
            rd_seen = fifo_read_o;
            cyc++;
            if (!arst) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    check("hold_data", m_data_o, hold_w.d);
                    check("hold_last", m_last_o, hold_w.l);
                    check("hold_src", m_src_o, hold_w.s);
                end
                hold_pending = m_valid_o && !m_ready_i;
                hold_w.d = m_data_o; hold_w.l = m_last_o; hold_w.s = m_src_o;
                if (m_valid_o && m_ready_i) begin
                    if (exp_w.size() == 0) begin
                        check("unexpected_word", m_data_o, 64'hDEAD_0000_0000);
                    end else begin
                        e = exp_w.pop_front();
                        check("word_data", m_data_o, e.d);
                        check("word_last", m_last_o, e.l);
                        check("word_src", m_src_o, e.s);
                        if (e.l) model_cnt++;
                        acc_cyc.push_back(cyc);
                    end
                end
                if (err_o) begin
                    if (exp_e.size() == 0) check("unexpected_err", err_code_o, 64'hDEAD);
                    else check("err_code", err_code_o, exp_e.pop_front());
                end
            end
        end
    end

    // Reference: parse the flit stream packet by packet and list expected words and errors.
    task automatic model_batch();
        int i = 0;
        int n = batch.size();
        int len, cnt;
        logic [7:0] src;
        logic [1:0] t;
        bit done;
        word_t w;
        while (i < n) begin
            if (batch[i][33:32] != 2'b00) begin
                exp_e.push_back(2'b01);
                i++;
                continue;
            end
            src = batch[i][31:24];
            len = int'(batch[i][23:16]);
            i++;
            if (len == 0) begin
                exp_e.push_back(2'b10);
                continue;
            end
            cnt = 0;
            done = 0;
            while (i < n && !done) begin
                t = batch[i][33:32];
                if (t == 2'b00) begin
                    exp_e.push_back(2'b11);
                    done = 1;
                end else if (t == 2'b11) begin
                    exp_e.push_back(2'b01);
                    i++;
                end else begin
                    w.d = batch[i][31:0];
                    w.s = src;
                    w.l = (t == 2'b10) || (cnt == len - 1);
                    exp_w.push_back(w);
                    i++;
                    if (t == 2'b10) begin
                        if (cnt != len - 1) exp_e.push_back(2'b10);
                        done = 1;
                    end else if (cnt == len - 1) begin
                        exp_e.push_back(2'b10);
                        while (i < n && batch[i][33:32] != 2'b00) begin
                            i++;
                            if (batch[i-1][33:32] == 2'b10) break;
                        end
                        done = 1;
                    end
                    cnt++;
                end
            end
        end
    endtask

    task automatic start_batch();
        model_batch();
        foreach (batch[k]) fq.push_back(batch[k]);
        batch.delete();
    endtask

    task automatic finish_batch(input string tag);
        bit ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if (fq.size() == 0 && exp_w.size() == 0 && !m_valid_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check({tag, "_timeout"}, 0, 1);
        repeat (3) @(posedge clk);
        #2;
        check({tag, "_words_left"}, exp_w.size(), 0);
        check({tag, "_errs_left"}, exp_e.size(), 0);
        check({tag, "_pkt_count"}, pkt_count_o, model_cnt % 65536);
        check({tag, "_pkt_count_w"}, w_pkt_count_o, model_cnt % 4);
        exp_w.delete();
        exp_e.delete();
    endtask

    task automatic good_packet(input logic [7:0] src, input int len);
        batch.push_back(head(src, 8'(len)));
        for (int k = 0; k < len; k++)
            batch.push_back(fl((k == len - 1) ? 2'b10 : 2'b01, $urandom));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int len, nf;
        logic [1:0] t;

        // Reset values, with a flit waiting so the pop strobe gating is exercised.
        fq.push_back(head(8'h33, 8'd2));
        repeat (3) @(posedge clk);
        #2;
        check("rst_fifo_read", fifo_read_o, 0);
        check("rst_valid", m_valid_o, 0);
        check("rst_data", m_data_o, 0);
        check("rst_last", m_last_o, 0);
        check("rst_src", m_src_o, 0);
        check("rst_err", err_o, 0);
        check("rst_code", err_code_o, 0);
        check("rst_count", pkt_count_o, 0);
        fq.delete();
        @(posedge clk); #2;
        arst = 1'b1;
        repeat (2) @(posedge clk);

        // Normal packet, words on consecutive cycles.
        ready_mode = 0;
        acc_cyc.delete();
        batch.push_back(head(8'h12, 8'd3));
        batch.push_back(fl(2'b01, 32'hA));
        batch.push_back(fl(2'b01, 32'hB));
        batch.push_back(fl(2'b10, 32'hC));
        start_batch();
        finish_batch("normal");
        check("normal_n_words", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            check("normal_gap1", acc_cyc[1] - acc_cyc[0], 1);
            check("normal_gap2", acc_cyc[2] - acc_cyc[1], 1);
        end
        check("normal_count1", pkt_count_o, 1);

        // Backpressure on the first word.
        ready_mode = 2;
        batch.push_back(head(8'h12, 8'd3));
        batch.push_back(fl(2'b01, 32'hA));
        batch.push_back(fl(2'b01, 32'hB));
        batch.push_back(fl(2'b10, 32'hC));
        start_batch();
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #2;
            if (m_valid_o) begin ok = 1; break; end
        end
        check("bp_valid_seen", ok, 1);
        check("bp_first_word", m_data_o, 32'hA);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            check("bp_hold_a", m_data_o, 32'hA);
            check("bp_hold_valid", m_valid_o, 1);
            check("bp_no_pop", fifo_read_o, 0);
        end
        ready_mode = 0;
        finish_batch("bp");

        // Stray body, then a good packet.
        batch.push_back(fl(2'b01, 32'h55));
        good_packet(8'h21, 2);
        start_batch();
        finish_batch("stray");

        // Short packet (tail early).
        batch.push_back(head(8'h40, 8'd3));
        batch.push_back(fl(2'b01, 32'h1));
        batch.push_back(fl(2'b10, 32'h2));
        start_batch();
        finish_batch("short");

        // Long packet (body at the length limit, rest drained).
        batch.push_back(head(8'h41, 8'd1));
        batch.push_back(fl(2'b01, 32'h11));
        batch.push_back(fl(2'b01, 32'h12));
        batch.push_back(fl(2'b10, 32'h13));
        start_batch();
        finish_batch("long");

        // Abort by a new head.
        batch.push_back(head(8'h50, 8'd4));
        batch.push_back(fl(2'b01, 32'h21));
        batch.push_back(head(8'h07, 8'd1));
        batch.push_back(fl(2'b10, 32'h9));
        start_batch();
        finish_batch("abort");

        // Randomized batches with random backpressure and injected faults.
        ready_mode = 1;
        for (int b = 0; b < 40; b++) begin
            for (int p = 0; p < int'($urandom_range(1, 4)); p++) begin
                if ($urandom_range(0, 9) == 0) batch.push_back(fl(2'($urandom_range(1, 3)), $urandom));
                len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
                batch.push_back(head(8'($urandom), 8'(len)));
                nf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : len;
                for (int k = 0; k < nf; k++) begin
                    t = (k == nf - 1) ? 2'b10 : 2'b01;
                    if ($urandom_range(0, 11) == 0) t = 2'($urandom);
                    batch.push_back(fl(t, $urandom));
                end
            end
            good_packet(8'hA5, 2);
            start_batch();
            finish_batch("rand");
        end

        // Reset mid-packet.
        ready_mode = 0;
        batch.push_back(head(8'h66, 8'd4));
        for (int k = 0; k < 4; k++) batch.push_back(fl((k == 3) ? 2'b10 : 2'b01, 32'h100 + k));
        start_batch();
        repeat (3) @(posedge clk);
        #2;
        arst = 1'b0;
        #1;
        check("mid_rst_fifo_read", fifo_read_o, 0);
        check("mid_rst_valid", m_valid_o, 0);
        check("mid_rst_data", m_data_o, 0);
        check("mid_rst_last", m_last_o, 0);
        check("mid_rst_src", m_src_o, 0);
        check("mid_rst_err", err_o, 0);
        check("mid_rst_code", err_code_o, 0);
        check("mid_rst_count", pkt_count_o, 0);
        fq.delete();
        exp_w.delete();
        exp_e.delete();
        model_cnt = 0;
        repeat (2) @(posedge clk);
        #2;
        arst = 1'b1;
        repeat (2) @(posedge clk);
        good_packet(8'h77, 3);
        start_batch();
        finish_batch("post_rst");

        // Counter wrap on the narrow copy: five more packets take it past 3.
        for (int p = 0; p < 5; p++) good_packet(8'h10 + 8'(p), 1);
        start_batch();
        finish_batch("wrap");
        check("wrap_narrow", w_pkt_count_o, 2'd2);
        check("wrap_wide", pkt_count_o, 16'd6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
